seg_mux_driver: RTL and testbench



---
 rtl/seg_pkg.sv | 18 +
 rtl/seg_hex_decoder.sv | 12 +
 rtl/seg_mux_driver.sv | 136 +++++++++++++
 tb/tb_seg_mux_driver.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/seg_pkg.sv
// Shared types and constants for the seven-segment display mux.
// Segment patterns are active-high, bit0 = a ... bit6 = g.
package seg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  // All segments dark, in active-high terms.
  localparam logic [6:0] SEG_OFF = 7'h00;

  localparam logic [6:0] SEG_TABLE [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

endpackage

// File: rtl/seg_hex_decoder.sv
// Combinational hex-to-seven-segment decoder, active-high gfedcba.
// Polarity and registering are handled by the caller.
module seg_hex_decoder
  import seg_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_mux_driver.sv
// Time-multiplexed seven-segment driver: each slot is a dark blanking
// interval followed by a lit phase showing a snapshot of one digit.
//
// Handshake: none. The display inputs are sampled only on the edge that
// ends a blanking interval; the inputs may change freely at any other time.
module seg_mux_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int DIV_COUNT      = 60000,
  parameter int BLANK_CYCLES   = 600,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int EN_ACTIVE_LOW  = 1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [4*NUM_DIGITS-1:0] digits,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic [NUM_DIGITS-1:0]   digit_en,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   en,
  output logic                    frame_start
);

  localparam int CNT_MAX = (DIV_COUNT > BLANK_CYCLES) ? DIV_COUNT : BLANK_CYCLES;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam int IDX_W   = $clog2(NUM_DIGITS);

  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] DIV_LAST   = CNT_W'(DIV_COUNT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

  localparam logic                  SEG_INV  = (SEG_ACTIVE_LOW != 0);
  localparam logic                  EN_INV   = (EN_ACTIVE_LOW != 0);
  localparam logic [6:0]            SEG_DARK = SEG_OFF ^ {7{SEG_INV}};
  localparam logic                  DP_DARK  = SEG_INV;
  localparam logic [NUM_DIGITS-1:0] EN_NONE  = {NUM_DIGITS{EN_INV}};

  state_t           state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [IDX_W-1:0] idx, idx_n;
  logic             load, unload;

  logic [3:0]            hex_sel;
  logic                  dp_sel;
  logic                  en_sel;
  logic [NUM_DIGITS-1:0] en_hot;
  logic [6:0]            seg_dec;

  // Explicit select loop keeps idx values beyond NUM_DIGITS-1 harmless.
  always_comb begin
    hex_sel = 4'h0;
    dp_sel  = 1'b0;
    en_sel  = 1'b0;
    en_hot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx == IDX_W'(i)) begin
        hex_sel   = digits[4*i +: 4];
        dp_sel    = dp_in[i];
        en_sel    = digit_en[i];
        en_hot[i] = 1'b1;
      end
    end
  end

  seg_hex_decoder u_dec (
    .hex (hex_sel),
    .seg (seg_dec)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= BLANK;
      cnt   <= '0;
      idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      idx   <= idx_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    load    = 1'b0;
    unload  = 1'b0;
    case (state)
      BLANK: begin
        if (cnt == BLANK_LAST) begin
          state_n = SHOW;
          cnt_n   = '0;
          load    = 1'b1;
        end
      end
      SHOW: begin
        if (cnt == DIV_LAST) begin
          state_n = BLANK;
          cnt_n   = '0;
          unload  = 1'b1;
          idx_n   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end
      end
      default: begin
        state_n = BLANK;
        cnt_n   = '0;
        idx_n   = '0;
      end
    endcase
  end

  // Output registers hold the snapshot for the whole lit phase.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg         <= SEG_DARK;
      dp          <= DP_DARK;
      en          <= EN_NONE;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (load) begin
        seg         <= en_sel ? (seg_dec ^ {7{SEG_INV}}) : SEG_DARK;
        dp          <= (en_sel && dp_sel) ? ~DP_DARK : DP_DARK;
        en          <= en_sel ? (en_hot ^ EN_NONE) : EN_NONE;
        frame_start <= (idx == '0);
      end else if (unload) begin
        seg <= SEG_DARK;
        dp  <= DP_DARK;
        en  <= EN_NONE;
      end
    end
  end

endmodule

// File: tb/tb_seg_mux_driver.sv
// Directed bench for seg_mux_driver with 3 digits, 4 lit / 2 dark cycles.
// Cycle 0 is the first cycle after reset release; outputs sampled on negedge.
module tb_seg_mux_driver;

  localparam int N = 3;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [11:0]  digits = 12'h210;
  logic [2:0]   dp_in = 3'b000;
  logic [2:0]   digit_en = 3'b111;
  logic [6:0]   seg;
  logic         dp;
  logic [2:0]   en;
  logic         frame_start;

  int n_vec = 0;
  int n_miss = 0;
  int cyc = -1;

  // Monitor state for the random phase.
  logic mon_on = 1'b0;
  int   last_act = -1;
  int   dark_run = 0;

  logic [2:0] t_en  [21] = '{
    3'b111, 3'b111, 3'b110, 3'b110, 3'b110, 3'b110, 3'b111, 3'b111,
    3'b101, 3'b101, 3'b101, 3'b101, 3'b111, 3'b111,
    3'b011, 3'b011, 3'b011, 3'b011, 3'b111, 3'b111, 3'b110
  };
  logic [6:0] t_seg [21] = '{
    7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40, 7'h7F, 7'h7F,
    7'h79, 7'h79, 7'h79, 7'h79, 7'h7F, 7'h7F,
    7'h24, 7'h24, 7'h24, 7'h24, 7'h7F, 7'h7F, 7'h40
  };

  logic [6:0] exp_q [$];

  seg_mux_driver #(
    .NUM_DIGITS     (N),
    .DIV_COUNT      (4),
    .BLANK_CYCLES   (2),
    .SEG_ACTIVE_LOW (1),
    .EN_ACTIVE_LOW  (1)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .digits      (digits),
    .dp_in       (dp_in),
    .digit_en    (digit_en),
    .seg         (seg),
    .dp          (dp),
    .en          (en),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s cycle=%0d got=%0h exp=%0h", tag, cyc, got, exp);
    end
  endtask

  task automatic wait_cycle(input int c);
    while (cyc < c) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    cyc = -1;
  endtask

  // Mutual exclusion and dark-gap monitor.
  always @(negedge clk) begin
    if (mon_on && !reset) begin
      int act;
      int nlow;
      nlow = 0;
      act = -1;
      for (int i = 0; i < N; i++) begin
        if (!en[i]) begin
          nlow++;
          act = i;
        end
      end
      check("onehot", (nlow <= 1), 1);
      if (nlow == 1) begin
        if (last_act >= 0 && act != last_act)
          check("dark_gap", (dark_run >= 2), 1);
        last_act = act;
        dark_run = 0;
      end else begin
        dark_run++;
      end
    end
  end

  initial begin
    // Test 1: basic frame, all digits enabled.
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      wait_cycle(c);
      check("t1_en", en, t_en[c]);
      check("t1_seg", seg, t_seg[c]);
      check("t1_dp", dp, 1'b1);
      check("t1_frame", frame_start, (c == 2 || c == 20));
    end

    // Test 2: digit 1 disabled keeps its slot dark.
    digit_en = 3'b101;
    do_reset();
    for (int c = 0; c <= 20; c++) begin
      wait_cycle(c);
      if (c >= 8 && c <= 11) begin
        check("t2_en_off", en, 3'b111);
        check("t2_seg_off", seg, 7'h7F);
      end else begin
        check("t2_en", en, t_en[c]);
        check("t2_seg", seg, t_seg[c]);
      end
    end
    check("t2_frame", frame_start, 1'b1);

    // Test 3: input change during lit phase is not shown until next frame.
    digit_en = 3'b111;
    do_reset();
    wait_cycle(3);
    check("t3_seg_c3", seg, 7'h40);
    digits[3:0] = 4'hF;
    wait_cycle(4);
    check("t3_seg_c4", seg, 7'h40);
    wait_cycle(5);
    check("t3_seg_c5", seg, 7'h40);
    wait_cycle(20);
    check("t3_seg_c20", seg, 7'h0E);
    check("t3_en_c20", en, 3'b110);
    wait_cycle(23);
    check("t3_seg_c23", seg, 7'h0E);

    // Test 4: full hex sweep on digit 0 with its decimal point on.
    exp_q = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    dp_in = 3'b001;
    digits = 12'h210;
    do_reset();
    for (int k = 0; k < 16; k++) begin
      logic [6:0] e;
      wait_cycle(18 * k);
      digits[3:0] = 4'(k);
      wait_cycle(18 * k + 3);
      e = exp_q.pop_front();
      check("t4_seg", seg, e);
      check("t4_dp_on", dp, 1'b0);
      wait_cycle(18 * k + 9);
      check("t4_dp_d1", dp, 1'b1);
      check("t4_seg_d1", seg, 7'h79);
    end
    check("t4_q_empty", exp_q.size(), 0);

    // Test 5: asynchronous reset in the middle of digit 1's lit phase.
    digits = 12'h210;
    do_reset();
    wait_cycle(9);
    check("t5_en_pre", en, 3'b101);
    reset = 1'b1;
    #1;
    check("t5_en_rst", en, 3'b111);
    check("t5_seg_rst", seg, 7'h7F);
    check("t5_dp_rst", dp, 1'b1);
    check("t5_frame_rst", frame_start, 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    cyc = -1;
    wait_cycle(1);
    check("t5_en_c1", en, 3'b111);
    wait_cycle(2);
    check("t5_en_c2", en, 3'b110);
    check("t5_seg_c2", seg, 7'h40);
    check("t5_frame_c2", frame_start, 1'b1);

    // Test 6: random contents and enables with the monitor running.
    do_reset();
    mon_on = 1'b1;
    for (int c = 0; c < 1000; c++) begin
      wait_cycle(c);
      digits = 12'($urandom);
      digit_en = 3'($urandom_range(0, 7));
      dp_in = 3'($urandom_range(0, 7));
    end
    mon_on = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
